uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one uart_tx serializer among N byte requesters. It also generates the serializer's bit clock (txck) from the system clock. It sequences tstart/txpd against the serializer's state output so that every frame latches fresh data and is followed by at least one idle (mark) bit. It sits between the on-chip byte producers and uart_tx.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the uart_tx scheduler: FSM states, uart_tx state codes
// and the default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_SEND   = 2'd3
  } sched_state_e;

  localparam logic [3:0] TX_ST_IDLE  = 4'd0;
  localparam logic [3:0] TX_ST_START = 4'd1;
  localparam logic [3:0] TX_ST_STOP  = 4'd10;

  // 100 MHz system clock / 115200 baud
  localparam int DIV_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit clock for uart_tx: counter 0..DIV-1, txck high for the
// upper half of the count so the rising edge lands on DIV/2-1 -> DIV/2.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic txck
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          txck_q, txck_d;

  always_comb begin
    cnt_d  = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
    // registered from the next count so txck is glitch-free and in step with cnt_q
    txck_d = (cnt_d >= CW'(DIV / 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      txck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      txck_q <= txck_d;
    end
  end

  assign txck = txck_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx among N byte producers; sequences
// tstart/txpd against uart_tx state so each frame carries fresh data.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         ack,
  output logic                 txck,
  output logic [7:0]           txpd,
  output logic                 tstart,
  input  logic [3:0]           tx_state,
  output logic                 busy,
  output logic [$clog2(N)-1:0] active_id
);

  localparam int ID_W = $clog2(N);

  // Handshake: req[i] is a level held until ack[i]; ack[i] is a one-clk pulse
  // meaning req_data[i] was captured. Dropping req before ack withdraws it.

  sched_state_e    state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            tstart_q, tstart_d;
  logic [ID_W:0]   pick;
  logic [ID_W-1:0] win;

  // First requester at or above ptr (mod N); MSB flags that one was found.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0]    r,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = ID_W'((int'(ptr) + off) % N);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .txck (txck)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    tstart_d = 1'b0;
    pick     = rr_pick(req, ptr_q);
    win      = pick[ID_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if ((|req) && (tx_state == TX_ST_IDLE)) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (pick[ID_W]) begin
          hold_d     = req_data[8*win +: 8];
          id_d       = win;
          ack_d[win] = 1'b1;
          ptr_d      = ID_W'((int'(win) + 1) % N);
          state_d    = ST_LAUNCH;
        end else begin
          // every request was withdrawn between IDLE and GRANT
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (tx_state == TX_ST_START) state_d = ST_SEND;
        else                         tstart_d = 1'b1;
      end
      ST_SEND: begin
        // tstart stays low through stop so uart_tx must pass through idle
        if (tx_state == TX_ST_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      tstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      tstart_q <= tstart_d;
    end
  end

  assign ack       = ack_q;
  assign txpd      = hold_q;
  assign tstart    = tstart_q;
  assign active_id = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx driving tx_state.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           txck;
  logic [7:0]     txpd;
  logic           tstart;
  logic [3:0]     tx_state;
  logic           busy;
  logic [1:0]     active_id;

  uart_tx_sched #(.N(N), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .txck      (txck),
    .txpd      (txpd),
    .tstart    (tstart),
    .tx_state  (tx_state),
    .busy      (busy),
    .active_id (active_id)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int frames  = 0;

  logic [10:0] exp_q[$];     // {id[2:0], byte} in expected grant order
  logic [7:0]  exp_frm_q[$]; // bytes expected on the serial line

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural uart_tx: state advances one clk after each txck rising edge
  logic [3:0] m_state;
  logic [7:0] m_buf;
  logic       txck_prev;
  logic [8:0] line_bits;
  logic [9:0] last_frame;
  logic       tx_line;

  assign tx_state = m_state;
  assign tx_line  = (m_state == TX_ST_START) ? 1'b0 :
                    ((m_state >= 4'd2) && (m_state <= 4'd9)) ? m_buf[3'(m_state - 4'd2)] : 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state    <= TX_ST_IDLE;
      m_buf      <= '0;
      txck_prev  <= 1'b0;
      line_bits  <= '0;
    end else begin
      txck_prev <= txck;
      if (m_state == TX_ST_IDLE) m_buf <= txpd;
      if (txck && !txck_prev) begin
        if (m_state == TX_ST_IDLE) begin
          if (tstart) begin
            m_state <= TX_ST_START;
            frames  <= frames + 1;
          end
        end else if (m_state == TX_ST_STOP) begin
          check("mark_gap", tstart, 0);
          check("stop_bit", tx_line, 1);
          check("start_bit", line_bits[0], 0);
          if (exp_frm_q.size() == 0) check("frame_unexp", exp_frm_q.size(), 1);
          else check("frame_byte", line_bits[8:1], exp_frm_q.pop_front());
          last_frame <= {tx_line, line_bits};
          m_state    <= tstart ? TX_ST_START : TX_ST_IDLE;
        end else begin
          line_bits[4'(m_state - 4'd1)] <= tx_line;
          m_state <= m_state + 4'd1;
        end
      end
    end
  end

  // scoreboard: every ack must match the next expected grant
  logic [10:0] e;
  always @(negedge clk) begin
    if (!rst && (ack != '0)) begin
      if (exp_q.size() == 0) check("ack_unexp", ack, 0);
      else begin
        e = exp_q.pop_front();
        check("ack_vec", ack, 32'd1 << e[10:8]);
        check("ack_id", active_id, e[10:8]);
        check("ack_txpd", txpd, e[7:0]);
        exp_frm_q.push_back(e[7:0]);
      end
    end
  end

  // driver tasks
  task automatic send(input int id, input logic [7:0] d, output int lat);
    lat = 0;
    req_data[8*id +: 8] = d;
    req[id] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[id] && lat < 600);
    if (!ack[id]) check($sformatf("ack_timeout_%0d", id), lat, 0);
    req[id] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    exp_frm_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (t < 3000 && (busy || m_state != TX_ST_IDLE || exp_q.size() != 0 || exp_frm_q.size() != 0)) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, t < 3000, 1);
    repeat (2) @(negedge clk);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_tx_state(input logic [3:0] s, input string tag);
    int t;
    t = 0;
    while (t < 1000 && m_state != s) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_reach"}, m_state, s);
  endtask

  task automatic measure_txck();
    int t, hi, lo;
    t = 0;
    while (t < 100 && txck) begin @(negedge clk); t++; end
    while (t < 100 && !txck) begin @(negedge clk); t++; end
    hi = 0;
    while (hi < 100 && txck) begin @(negedge clk); hi++; end
    lo = 0;
    while (lo < 100 && !txck) begin @(negedge clk); lo++; end
    check("txck_high", hi, DIV / 2);
    check("txck_low", lo, DIV / 2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, l0, l1, l2, l3, f0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_txck", txck, 0);
    check("rst_txpd", txpd, 0);
    check("rst_tstart", tstart, 0);
    check("rst_busy", busy, 0);
    check("rst_active_id", active_id, 0);
    check("rst_tx_state", tx_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // single send
    measure_txck();
    exp_q.push_back({3'd0, 8'h55});
    send(0, 8'h55, lat);
    check("single_lat", lat, 2);
    check("single_tstart_pre", tstart, 0);
    @(negedge clk);
    check("single_tstart_rise", tstart, 1);
    check("single_busy", busy, 1);
    wait_done("single");
    check("single_line", last_frame, 10'h2AA);

    // contention 0 and 2
    do_reset();
    exp_q.push_back({3'd0, 8'hA5});
    exp_q.push_back({3'd2, 8'h3C});
    fork
      send(0, 8'hA5, l0);
      send(2, 8'h3C, l2);
    join
    wait_done("cont");

    // round-robin fairness
    do_reset();
    f0 = frames;
    exp_q.push_back({3'd0, 8'h10});
    exp_q.push_back({3'd1, 8'h21});
    exp_q.push_back({3'd2, 8'h32});
    exp_q.push_back({3'd3, 8'h43});
    exp_q.push_back({3'd0, 8'h14});
    exp_q.push_back({3'd1, 8'h25});
    fork
      begin send(0, 8'h10, l0); send(0, 8'h14, l0); end
      begin send(1, 8'h21, l1); send(1, 8'h25, l1); end
      send(2, 8'h32, l2);
      send(3, 8'h43, l3);
    join
    wait_done("rr");
    check("rr_frames", frames - f0, 6);

    // back-to-back same requester
    do_reset();
    f0 = frames;
    exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd1, 8'hFF});
    send(1, 8'h00, l1);
    send(1, 8'hFF, l1);
    wait_done("b2b");
    check("b2b_frames", frames - f0, 2);

    // mid-frame reset, then pointer must be back at 0
    do_reset();
    exp_q.push_back({3'd0, 8'h96});
    send(0, 8'h96, l0);
    wait_tx_state(4'd5, "midrst");
    rst = 1'b1;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_tstart", tstart, 0);
    check("midrst_txck", txck, 0);
    check("midrst_busy", busy, 0);
    check("midrst_txpd", txpd, 0);
    check("midrst_tx_state", tx_state, 0);
    exp_q.delete();
    exp_frm_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back({3'd0, 8'h5A});
    exp_q.push_back({3'd1, 8'h6B});
    fork
      send(0, 8'h5A, l0);
      send(1, 8'h6B, l1);
    join
    wait_done("postrst");

    // withdrawn request during a frame
    do_reset();
    f0 = frames;
    exp_q.push_back({3'd0, 8'h81});
    send(0, 8'h81, l0);
    wait_tx_state(4'd3, "wd");
    req_data[31:24] = 8'hEE;
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    wait_done("wd");
    repeat (40) @(negedge clk);
    check("wd_frames", frames - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
